pcileech_com_act_gate: RTL

Sits in the clk domain between the FT601 receive path of pcileech_com (64-bit dout/valid stream) and the dcom input of pcileech_fifo. It detects activation and interrupt-enable command words within the synchronised receive stream and removes them from that stream. It also gates all non-command traffic to the FIFO and the FT601 transmit path while the device is locked. This replaces sampling of raw ft601_data pads in the top level.

---
 rtl/pcileech_com_act_gate.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pcileech_com_act_gate.sv
// Command-word gate between the FT601 receive stream and the FIFO dcom input.
// Strips activation/interrupt/lock codes and holds back data traffic while locked.
module pcileech_com_act_gate #(
  parameter logic [31:0] CODE_ENABLE    = 32'h49901330,
  parameter logic [31:0] CODE_INT       = 32'h52322313,
  parameter logic [31:0] CODE_DISABLE   = 32'hF2F2D2D2,
  parameter int unsigned MATCH_REPEAT   = 2,
  parameter bit          DEFAULT_ACTIVE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] in_dout,
  input  logic        in_valid,
  output logic [63:0] out_dout,
  output logic        out_valid,
  output logic        tx_allow,
  output logic        activated,
  output logic        int_enable,
  output logic [15:0] drop_count
);

  typedef enum logic {ST_LOCKED, ST_ACTIVE} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_EN, TAG_INT, TAG_DIS} tag_t;

  localparam logic [3:0] REPEAT      = 4'(MATCH_REPEAT);
  localparam state_t     RESET_STATE = DEFAULT_ACTIVE ? ST_ACTIVE : ST_LOCKED;

  state_t      state_reg, state_next;
  tag_t        last_code_reg, last_code_next;
  logic [3:0]  seq_cnt_reg, seq_cnt_next;
  logic        int_enable_reg, int_enable_next;
  logic [63:0] out_dout_reg, out_dout_next;
  logic        out_valid_reg, out_valid_next;
  logic [15:0] drop_count_reg, drop_count_next;

  tag_t code_tag;
  logic hit_en, hit_int, hit_dis;
  logic fire;

  always_comb begin
    hit_en  = (in_dout[63:32] == CODE_ENABLE)  && (in_dout[31:0] == CODE_ENABLE);
    hit_int = (in_dout[63:32] == CODE_INT)     && (in_dout[31:0] == CODE_INT);
    hit_dis = (in_dout[63:32] == CODE_DISABLE) && (in_dout[31:0] == CODE_DISABLE);
    // Overlapping code values resolve with lock taking precedence.
    code_tag = TAG_NONE;
    if (hit_dis)      code_tag = TAG_DIS;
    else if (hit_en)  code_tag = TAG_EN;
    else if (hit_int) code_tag = TAG_INT;
  end

  always_comb begin
    state_next      = state_reg;
    last_code_next  = last_code_reg;
    seq_cnt_next    = seq_cnt_reg;
    int_enable_next = int_enable_reg;
    out_dout_next   = in_dout;
    out_valid_next  = 1'b0;
    drop_count_next = drop_count_reg;
    fire            = 1'b0;

    if (in_valid) begin
      if (code_tag == TAG_NONE) begin
        last_code_next = TAG_NONE;
        seq_cnt_next   = 4'd0;
        if (state_reg == ST_ACTIVE)
          out_valid_next = 1'b1;
        else if (drop_count_reg != 16'hFFFF)
          drop_count_next = drop_count_reg + 16'd1;
      end else if (code_tag == last_code_reg) begin
        // Fire only on the step into REPEAT; a saturated run stays quiet.
        if (seq_cnt_reg < REPEAT) begin
          seq_cnt_next = seq_cnt_reg + 4'd1;
          fire         = (seq_cnt_reg + 4'd1 == REPEAT);
        end
      end else begin
        last_code_next = code_tag;
        seq_cnt_next   = 4'd1;
        fire           = (REPEAT == 4'd1);
      end
    end

    if (fire) begin
      case (code_tag)
        TAG_EN:  state_next = ST_ACTIVE;
        TAG_INT: int_enable_next = 1'b1;
        TAG_DIS: begin
          state_next      = ST_LOCKED;
          int_enable_next = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= RESET_STATE;
      last_code_reg  <= TAG_NONE;
      seq_cnt_reg    <= 4'd0;
      int_enable_reg <= 1'b0;
      out_dout_reg   <= 64'd0;
      out_valid_reg  <= 1'b0;
      drop_count_reg <= 16'd0;
    end else begin
      state_reg      <= state_next;
      last_code_reg  <= last_code_next;
      seq_cnt_reg    <= seq_cnt_next;
      int_enable_reg <= int_enable_next;
      out_dout_reg   <= out_dout_next;
      out_valid_reg  <= out_valid_next;
      drop_count_reg <= drop_count_next;
    end
  end

  assign out_dout   = out_dout_reg;
  assign out_valid  = out_valid_reg;
  assign activated  = (state_reg == ST_ACTIVE);
  assign tx_allow   = (state_reg == ST_ACTIVE);
  assign int_enable = int_enable_reg;
  assign drop_count = drop_count_reg;

endmodule
